// File: rtl/pix_pack.sv
// pix_pack: byte-to-pixel packer feeding the LED FIFO.
//
// Gathers 3 (RGB, FORMAT=0) or 4 (RGBW, FORMAT=1) bytes per pixel and writes
// one 34-bit FIFO word per pixel: [33] last pixel of frame, [32] first pixel
// of frame, [31:0] pixel data. A frame ending mid-pixel is padded with
// PAD_VALUE and flags the sticky RUNT bit.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   ENABLE              low = flush partial pixel / pending word and idle
//   FORMAT              bytes per pixel select, latched on a frame's first byte
//   IN_VALID/IN_DATA/IN_LAST/IN_READY   byte stream handshake
//   FIFO_FULL           back-pressure from the LED FIFO
//   FIFO_WE/FIFO_WDATA  FIFO write strobe and word
//   FRAME_DONE          pulse with the write of a frame's last word
//   PIXEL_COUNT         pixels in the most recently completed frame
//   RUNT/RUNT_CLR       sticky runt-pixel flag and its clear
//
// Build option: define PIX_PACK_RG_SWAP_EN to swap the output positions of
// byte0 and byte1 (GRB strip ordering) in both formats.

module pix_pack #(
    parameter int          CNT_W     = 16,
    parameter logic [7:0]  PAD_VALUE = 8'h00
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic             FORMAT,
    input  logic             IN_VALID,
    input  logic [7:0]       IN_DATA,
    input  logic             IN_LAST,
    output logic             IN_READY,
    input  logic             FIFO_FULL,
    output logic             FIFO_WE,
    output logic [33:0]      FIFO_WDATA,
    output logic             FRAME_DONE,
    output logic [CNT_W-1:0] PIXEL_COUNT,
    output logic             RUNT,
    input  logic             RUNT_CLR
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_EMIT    = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_r;
    logic [1:0]       idx_r;
    logic             first_r;
    logic             fmt_r;
    logic [7:0]       b0_r, b1_r, b2_r;
    logic [33:0]      word_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] pix_cnt_r;
    logic             runt_r;

    logic             srst_s;
    logic             accept_s;
    logic             fmt_s;
    logic [1:0]       last_idx_s;
    logic             done_s;
    logic             runt_s;
    logic [7:0]       p0_s, p1_s, p2_s, p3_s;

    // Place the four pixel bytes into the 32-bit data field.
    function automatic logic [31:0] pack_pixel(input logic fmt, input logic [7:0] p0,
                                               input logic [7:0] p1, input logic [7:0] p2,
                                               input logic [7:0] p3);
        logic [31:0] w;
`ifdef PIX_PACK_RG_SWAP_EN
        if (fmt) w = {p1, p0, p2, p3};
        else     w = {8'h00, p1, p0, p2};
`else
        if (fmt) w = {p0, p1, p2, p3};
        else     w = {8'h00, p0, p1, p2};
`endif
        return w;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    // Handshake, completion detection and padded byte selection.
    always_comb begin
        srst_s   = !ENABLE;
        IN_READY = ENABLE && (state_r == ST_COLLECT);
        accept_s = IN_VALID && IN_READY;
        // The frame's first byte uses the live FORMAT; later bytes use the latch.
        if ((idx_r == 2'd0) && first_r) fmt_s = FORMAT;
        else                            fmt_s = fmt_r;
        last_idx_s = fmt_s ? 2'd3 : 2'd2;
        done_s     = accept_s && (IN_LAST || (idx_r == last_idx_s));
        runt_s     = accept_s && IN_LAST && (idx_r != last_idx_s);
        // Earlier bytes come from storage, the current byte is live, later ones pad.
        if (idx_r == 2'd0) p0_s = IN_DATA;
        else               p0_s = b0_r;
        if (idx_r == 2'd1)     p1_s = IN_DATA;
        else if (idx_r > 2'd1) p1_s = b1_r;
        else                   p1_s = PAD_VALUE;
        if (idx_r == 2'd2)     p2_s = IN_DATA;
        else if (idx_r > 2'd2) p2_s = b2_r;
        else                   p2_s = PAD_VALUE;
        if (idx_r == 2'd3) p3_s = IN_DATA;
        else               p3_s = PAD_VALUE;
    end

    // FIFO side: the write is gated by FIFO_FULL in the same cycle so a word is
    // written exactly once, in the first cycle the FIFO has room.
    always_comb begin
        FIFO_WE    = ENABLE && (state_r == ST_EMIT) && !FIFO_FULL;
        FIFO_WDATA = word_r;
        FRAME_DONE = FIFO_WE && word_r[33];
    end

    // Collect/emit state machine, byte storage and pending word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_COLLECT;
            idx_r   <= 2'd0;
            first_r <= 1'b1;
            fmt_r   <= 1'b0;
            b0_r    <= 8'h00;
            b1_r    <= 8'h00;
            b2_r    <= 8'h00;
            word_r  <= 34'd0;
        end else if (srst_s) begin
            state_r <= ST_COLLECT;
            idx_r   <= 2'd0;
            first_r <= 1'b1;
            fmt_r   <= 1'b0;
            b0_r    <= 8'h00;
            b1_r    <= 8'h00;
            b2_r    <= 8'h00;
            word_r  <= 34'd0;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (accept_s) begin
                        fmt_r <= fmt_s;
                        if (done_s) begin
                            word_r  <= {IN_LAST, first_r,
                                        pack_pixel(fmt_s, p0_s, p1_s, p2_s, p3_s)};
                            idx_r   <= 2'd0;
                            state_r <= ST_EMIT;
                        end else begin
                            idx_r <= idx_r + 2'd1;
                            case (idx_r)
                                2'd0:    b0_r <= IN_DATA;
                                2'd1:    b1_r <= IN_DATA;
                                2'd2:    b2_r <= IN_DATA;
                                default: b2_r <= b2_r;
                            endcase
                        end
                    end
                end
                ST_EMIT: begin
                    if (FIFO_WE) begin
                        state_r <= ST_COLLECT;
                        // A written last word re-arms the first flag for the next frame.
                        first_r <= word_r[33];
                    end
                end
                default: state_r <= ST_COLLECT;
            endcase
        end
    end

    // Pixel counter, completed-frame count and sticky runt flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r     <= {CNT_W{1'b0}};
            pix_cnt_r <= {CNT_W{1'b0}};
            runt_r    <= 1'b0;
        end else begin
            if (runt_s)        runt_r <= 1'b1;
            else if (RUNT_CLR) runt_r <= 1'b0;
            else               runt_r <= runt_r;
            if (srst_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (FIFO_WE) begin
                if (word_r[33]) begin
                    pix_cnt_r <= sat_inc(cnt_r);
                    cnt_r     <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= sat_inc(cnt_r);
                end
            end
        end
    end

    assign PIXEL_COUNT = pix_cnt_r;
    assign RUNT        = runt_r;

endmodule

// File: tb/tb_pix_pack.sv
// Scoreboard bench for pix_pack: stimulus pushes expected FIFO words, a
// monitor pops and compares them whenever FIFO_WE is seen.
module tb_pix_pack;

    logic        CLK = 1'b0;
    logic        RST_N, ENABLE, FORMAT, IN_VALID, IN_LAST, FIFO_FULL, RUNT_CLR;
    logic [7:0]  IN_DATA;
    logic        IN_READY, FIFO_WE, FRAME_DONE, RUNT;
    logic [33:0] FIFO_WDATA;
    logic [15:0] PIXEL_COUNT;

    int tests = 0;
    int fails = 0;
    logic [33:0] sb[$];

    pix_pack #(.CNT_W(16), .PAD_VALUE(8'h00)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .FORMAT(FORMAT),
        .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .IN_READY(IN_READY),
        .FIFO_FULL(FIFO_FULL), .FIFO_WE(FIFO_WE), .FIFO_WDATA(FIFO_WDATA),
        .FRAME_DONE(FRAME_DONE), .PIXEL_COUNT(PIXEL_COUNT), .RUNT(RUNT), .RUNT_CLR(RUNT_CLR)
    );

    always #5 CLK = ~CLK;

`ifdef PIX_PACK_RG_SWAP_EN
    localparam logic [33:0] E1A = 34'h1_0022_1133;
    localparam logic [33:0] E1B = 34'h2_0055_4466;
    localparam logic [33:0] E2  = 34'h3_BBAA_CCDD;
    localparam logic [33:0] E3  = 34'h3_0088_7799;
    localparam logic [33:0] E4  = 34'h3_0201_0000;
    localparam logic [33:0] E5  = 34'h3_0020_1030;
    localparam logic [33:0] E6  = 34'h3_0022_1133;
`else
    localparam logic [33:0] E1A = 34'h1_0011_2233;
    localparam logic [33:0] E1B = 34'h2_0044_5566;
    localparam logic [33:0] E2  = 34'h3_AABB_CCDD;
    localparam logic [33:0] E3  = 34'h3_0077_8899;
    localparam logic [33:0] E4  = 34'h3_0102_0000;
    localparam logic [33:0] E5  = 34'h3_0010_2030;
    localparam logic [33:0] E6  = 34'h3_0011_2233;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write must match the oldest expected word.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (FIFO_WE) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got %0h, expected no write", FIFO_WDATA);
                end else begin
                    logic [33:0] e;
                    e = sb.pop_front();
                    chk("wdata", FIFO_WDATA, e);
                    chk("frame_done", FRAME_DONE, e[33]);
                end
            end else begin
                chk("frame_done_idle", FRAME_DONE, 1'b0);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        IN_VALID = 1'b1;
        IN_DATA  = d;
        IN_LAST  = l;
        n = 0;
        forever begin
            @(negedge CLK);
            if (IN_READY) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", IN_READY, 1'b1);
                break;
            end
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge CLK);
        chk("drain", sb.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; ENABLE = 1'b0; FORMAT = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00;
        IN_LAST = 1'b0; FIFO_FULL = 1'b0; RUNT_CLR = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_in_ready", IN_READY, 1'b0);
        chk("rst_we", FIFO_WE, 1'b0);
        chk("rst_wdata", FIFO_WDATA, 34'd0);
        chk("rst_pixcnt", PIXEL_COUNT, 16'd0);
        chk("rst_runt", RUNT, 1'b0);
        chk("rst_frame_done", FRAME_DONE, 1'b0);
        @(posedge CLK); #1; RST_N = 1'b1;
        @(posedge CLK); #1; ENABLE = 1'b1;

        // Two-pixel RGB frame; FORMAT flipped mid-frame must be ignored.
        FORMAT = 1'b0;
        sb.push_back(E1A); sb.push_back(E1B);
        send(8'h11, 1'b0);
        FORMAT = 1'b1;
        send(8'h22, 1'b0); send(8'h33, 1'b0);
        send(8'h44, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b1);
        wait_drain();
        chk("t1_pixcnt", PIXEL_COUNT, 16'd2);
        chk("t1_runt", RUNT, 1'b0);

        // Flush mid-pixel, then a clean single-pixel frame.
        FORMAT = 1'b0;
        send(8'hEE, 1'b0);
        ENABLE = 1'b0;
        @(posedge CLK); #1; ENABLE = 1'b1;
        sb.push_back(E5);
        send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b1);
        wait_drain();
        chk("t5_pixcnt", PIXEL_COUNT, 16'd1);

        // RGBW pixel: write exactly one cycle after the last byte.
        FORMAT = 1'b1;
        sb.push_back(E2);
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b1);
        @(negedge CLK);
        chk("t2_we_latency", FIFO_WE, 1'b1);
        wait_drain();
        chk("t2_pixcnt", PIXEL_COUNT, 16'd1);

        // Back-pressure: FIFO full for 5 cycles after completion.
        FORMAT = 1'b0;
        sb.push_back(E3);
        send(8'h77, 1'b0); send(8'h88, 1'b0);
        FIFO_FULL = 1'b1;
        send(8'h99, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("t3_ready_full", IN_READY, 1'b0);
            chk("t3_we_full", FIFO_WE, 1'b0);
        end
        @(posedge CLK); #1; FIFO_FULL = 1'b0;
        @(negedge CLK);
        chk("t3_we_release", FIFO_WE, 1'b1);
        @(negedge CLK);
        chk("t3_we_once", FIFO_WE, 1'b0);
        chk("t3_ready_back", IN_READY, 1'b1);
        wait_drain();

        // Runt RGBW pixel, then clear RUNT.
        FORMAT = 1'b1;
        sb.push_back(E4);
        send(8'h01, 1'b0); send(8'h02, 1'b1);
        chk("t4_runt_set", RUNT, 1'b1);
        wait_drain();
        chk("t4_pixcnt", PIXEL_COUNT, 16'd1);
        RUNT_CLR = 1'b1;
        @(posedge CLK); #1; RUNT_CLR = 1'b0;
        chk("t4_runt_clr", RUNT, 1'b0);

        // Single RGB pixel 11,22,33 (placement depends on build option).
        FORMAT = 1'b0;
        sb.push_back(E6);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b1);
        wait_drain();
        chk("t6_pixcnt", PIXEL_COUNT, 16'd1);
        chk("t6_runt", RUNT, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
